// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder.
// Holds the FSM encoding, doubleword geometry and the address error rule.
package data_mem_responder_pkg;

    localparam int ADDR_W   = 64;
    localparam int DWORD_W  = 64;
    localparam int OFFSET_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    // Misaligned, or past the last doubleword of the array.
    function automatic logic addr_error(input logic [ADDR_W-1:0] addr,
                                        input int unsigned       depth);
        logic [ADDR_W-1:0] dword_idx;
        dword_idx = {{OFFSET_W{1'b0}}, addr[ADDR_W-1:OFFSET_W]};
        return (addr[OFFSET_W-1:0] != '0) || (dword_idx >= ADDR_W'(depth));
    endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// Doubleword storage: one synchronous write port, one combinational read port,
// five live debug taps and a synchronous active-low clear of every word.
module dmr_array
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [IDX_W-1:0]   waddr,
    input  logic [DWORD_W-1:0] wdata,
    input  logic [IDX_W-1:0]   raddr,
    output logic [DWORD_W-1:0] rdata,
    output logic [DWORD_W-1:0] dbg_word0,
    output logic [DWORD_W-1:0] dbg_word1,
    output logic [DWORD_W-1:0] dbg_word2,
    output logic [DWORD_W-1:0] dbg_word3,
    output logic [DWORD_W-1:0] dbg_word4
);

    logic [DWORD_W-1:0] mem  [DEPTH];
    logic [DWORD_W-1:0] taps [5];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

    // Taps beyond the end of a small array read as zero.
    for (genvar g = 0; g < 5; g++) begin : g_tap
        if (g < DEPTH) begin : g_live
            assign taps[g] = mem[g];
        end else begin : g_zero
            assign taps[g] = '0;
        end
    end

    assign dbg_word0 = taps[0];
    assign dbg_word1 = taps[1];
    assign dbg_word2 = taps[2];
    assign dbg_word3 = taps[3];
    assign dbg_word4 = taps[4];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding doubleword memory responder with a fixed wait latency.
// The request is committed to the array at the end of the wait period.
//
// state   | meaning
// IDLE    | ready for a request; req_ready = 1
// WAIT    | request captured, down-counter running to terminal count 0
// RESPOND | response held on rsp_* until rsp_ready
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [DWORD_W-1:0] req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DWORD_W-1:0] rsp_rdata,
    output logic               rsp_error,
    output logic [DWORD_W-1:0] dbg_word0,
    output logic [DWORD_W-1:0] dbg_word1,
    output logic [DWORD_W-1:0] dbg_word2,
    output logic [DWORD_W-1:0] dbg_word3,
    output logic [DWORD_W-1:0] dbg_word4
);

    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               accept, commit;

    logic               wr_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DWORD_W-1:0] wdata_q;
    logic [DWORD_W-1:0] rdata_q;
    logic               error_q;

    logic               c_write;
    logic [ADDR_W-1:0]  c_addr;
    logic [DWORD_W-1:0] c_wdata;
    logic               c_error;
    logic [IDX_W-1:0]   c_idx;
    logic               arr_we;
    logic [DWORD_W-1:0] arr_rdata;

    // With zero latency the commit happens on the acceptance edge, so the
    // live request is used instead of the (not yet loaded) capture registers.
    always_comb begin
        c_write = wr_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        if (state_q == IDLE) begin
            c_write = req_write;
            c_addr  = req_addr;
            c_wdata = req_wdata;
        end
    end

    assign c_error = addr_error(c_addr, DEPTH);
    assign c_idx   = c_addr[OFFSET_W +: IDX_W];
    assign arr_we  = commit && c_write && !c_error;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        commit  = 1'b1;
                        state_d = RESPOND;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESPOND: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (commit) begin
                rdata_q <= (c_write || c_error) ? '0 : arr_rdata;
                error_q <= c_error;
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESPOND);
    // Response fields are forced quiet outside RESPOND.
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_error = rsp_valid && error_q;

    dmr_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .we        (arr_we),
        .waddr     (c_idx),
        .wdata     (c_wdata),
        .raddr     (c_idx),
        .rdata     (arr_rdata),
        .dbg_word0 (dbg_word0),
        .dbg_word1 (dbg_word1),
        .dbg_word2 (dbg_word2),
        .dbg_word3 (dbg_word3),
        .dbg_word4 (dbg_word4)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2/DEPTH=64 instance and a
// LATENCY=0/DEPTH=4 instance, table vectors plus hand-written corner sequences.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_error;
    logic [63:0] req_addr, req_wdata, rsp_rdata;
    logic [63:0] dbg0, dbg1, dbg2, dbg3, dbg4;

    logic        z_req_valid, z_req_ready, z_req_write, z_rsp_valid, z_rsp_ready, z_rsp_error;
    logic [63:0] z_req_addr, z_req_wdata, z_rsp_rdata;
    logic [63:0] z_dbg0, z_dbg1, z_dbg2, z_dbg3, z_dbg4;

    data_mem_responder #(.DEPTH(64), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .dbg_word0(dbg0), .dbg_word1(dbg1), .dbg_word2(dbg2),
        .dbg_word3(dbg3), .dbg_word4(dbg4)
    );

    data_mem_responder #(.DEPTH(4), .LATENCY(0)) dut_z (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_error(z_rsp_error),
        .dbg_word0(z_dbg0), .dbg_word1(z_dbg1), .dbg_word2(z_dbg2),
        .dbg_word3(z_dbg3), .dbg_word4(z_dbg4)
    );

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs   [13];
    vec_t z_vecs [6];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Response fields must read zero whenever no response is presented.
    always @(negedge clk) begin
        if (reset === 1'b1 && rsp_valid === 1'b0) begin
            check("quiet_rdata", rsp_rdata, 64'h0);
            check("quiet_error", 64'(rsp_error), 64'h0);
        end
        if (reset === 1'b1 && z_rsp_valid === 1'b0) begin
            check("z_quiet_rdata", z_rsp_rdata, 64'h0);
            check("z_quiet_error", 64'(z_rsp_error), 64'h0);
        end
    end

    // Called just after a falling edge with the DUT idle; returns just after
    // the acceptance edge with req_valid dropped.
    task automatic issue(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] exp_rdata, input logic exp_err);
        check("req_ready_idle", 64'(req_ready), 64'h1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        exp_q.push_back(exp_t'{exp_rdata, exp_err});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Waits for the response, checks latency and scoreboard entry. With
    // rsp_ready high it returns at the falling edge after the handshake.
    task automatic await_rsp(input string name);
        int   n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_valid !== 1'b1 && n < 20);
        check({name, "_latency"}, 64'(n), 64'd3);
        if (exp_q.size() == 0) begin
            check({name, "_scoreboard_empty"}, 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({name, "_rdata"}, rsp_rdata, e.rdata);
            check({name, "_error"}, 64'(rsp_error), 64'(e.err));
        end
        if (rsp_ready) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int busy;

        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_rsp_ready = 1'b1;

        vecs[0]  = '{1'b1, 64'h10,  64'hDEADBEEF_CAFEF00D, 64'h0, 1'b0};
        vecs[1]  = '{1'b0, 64'h10,  64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0};
        vecs[2]  = '{1'b1, 64'h0C,  64'h1111, 64'h0, 1'b1};
        vecs[3]  = '{1'b0, 64'h08,  64'h0, 64'h0, 1'b0};
        vecs[4]  = '{1'b0, 64'h200, 64'h0, 64'h0, 1'b1};
        vecs[5]  = '{1'b1, 64'h00,  64'h01234567_89ABCDEF, 64'h0, 1'b0};
        vecs[6]  = '{1'b1, 64'h20,  64'hA5A5A5A5_5A5A5A5A, 64'h0, 1'b0};
        vecs[7]  = '{1'b0, 64'h00,  64'h0, 64'h01234567_89ABCDEF, 1'b0};
        vecs[8]  = '{1'b0, 64'h1F8, 64'h0, 64'h0, 1'b0};
        vecs[9]  = '{1'b1, 64'h1F8, 64'h5555, 64'h0, 1'b0};
        vecs[10] = '{1'b0, 64'h1F8, 64'h0, 64'h5555, 1'b0};
        vecs[11] = '{1'b1, 64'h1FF, 64'h9999, 64'h0, 1'b1};
        vecs[12] = '{1'b0, 64'hFFFFFFFF_FFFFFFF8, 64'h0, 64'h0, 1'b1};

        z_vecs[0] = '{1'b1, 64'h08, 64'h11112222_33334444, 64'h0, 1'b0};
        z_vecs[1] = '{1'b0, 64'h08, 64'h0, 64'h11112222_33334444, 1'b0};
        z_vecs[2] = '{1'b1, 64'h0C, 64'hFF, 64'h0, 1'b1};
        z_vecs[3] = '{1'b1, 64'h18, 64'h77, 64'h0, 1'b0};
        z_vecs[4] = '{1'b0, 64'h20, 64'h0, 64'h0, 1'b1};
        z_vecs[5] = '{1'b0, 64'h18, 64'h0, 64'h77, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("rst_req_ready", 64'(req_ready), 64'h1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_dbg0", dbg0, 64'h0);
        check("rst_dbg1", dbg1, 64'h0);
        check("rst_dbg2", dbg2, 64'h0);
        check("rst_dbg3", dbg3, 64'h0);
        check("rst_dbg4", dbg4, 64'h0);

        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err);
            await_rsp($sformatf("vec%0d", i));
        end
        check("tbl_dbg0", dbg0, 64'h01234567_89ABCDEF);
        check("tbl_dbg1", dbg1, 64'h0);
        check("tbl_dbg2", dbg2, 64'hDEADBEEF_CAFEF00D);
        check("tbl_dbg3", dbg3, 64'h0);
        check("tbl_dbg4", dbg4, 64'hA5A5A5A5_5A5A5A5A);

        // Backpressure: response held for 5 further cycles, stray request ignored.
        rsp_ready = 1'b0;
        issue(1'b0, 64'h10, 64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0);
        await_rsp("bp");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", 64'(rsp_valid), 64'h1);
            check("bp_rdata", rsp_rdata, 64'hDEADBEEF_CAFEF00D);
            check("bp_req_ready", 64'(req_ready), 64'h0);
            if (k == 1) begin
                req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h0; req_wdata = 64'hBAD;
            end else if (k == 2) begin
                req_valid = 1'b0;
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        busy = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) busy++;
        end
        check("bp_not_queued", 64'(busy), 64'h0);
        check("bp_dbg0_kept", dbg0, 64'h01234567_89ABCDEF);

        // Abort: reset while a write waits.
        issue(1'b1, 64'h08, 64'h1234, 64'h0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        void'(exp_q.pop_front());
        check("abort_req_ready", 64'(req_ready), 64'h1);
        check("abort_rsp_valid", 64'(rsp_valid), 64'h0);
        busy = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) busy++;
        end
        check("abort_no_rsp", 64'(busy), 64'h0);
        check("abort_dbg1", dbg1, 64'h0);
        check("abort_dbg2_cleared", dbg2, 64'h0);

        // Zero latency, back-to-back with req_valid held high.
        z_req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            check($sformatf("z%0d_req_ready", i), 64'(z_req_ready), 64'h1);
            z_req_write = z_vecs[i].wr;
            z_req_addr  = z_vecs[i].addr;
            z_req_wdata = z_vecs[i].wdata;
            exp_q.push_back(exp_t'{z_vecs[i].rdata, z_vecs[i].err});
            @(negedge clk);
            check($sformatf("z%0d_rsp_valid", i), 64'(z_rsp_valid), 64'h1);
            check($sformatf("z%0d_busy", i), 64'(z_req_ready), 64'h0);
            e = exp_q.pop_front();
            check($sformatf("z%0d_rdata", i), z_rsp_rdata, e.rdata);
            check($sformatf("z%0d_error", i), 64'(z_rsp_error), 64'(e.err));
            @(negedge clk);
        end
        z_req_valid = 1'b0;
        check("z_dbg0", z_dbg0, 64'h0);
        check("z_dbg1", z_dbg1, 64'h11112222_33334444);
        check("z_dbg2", z_dbg2, 64'h0);
        check("z_dbg3", z_dbg3, 64'h77);
        check("z_dbg4_missing", z_dbg4, 64'h0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 64, is the number of 64-bit doublewords in the array.
REQ-002 Parameter LATENCY, default 2, is the number of wait cycles between request acceptance and response; the legal range is 0..15.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset is synchronous and active-low.
REQ-005 req_valid  input  1  the processor-side memory stage presents a request.
REQ-006 req_ready  output  1  the block can accept a request this cycle.
REQ-007 req_write  input  1  1 = store doubleword, 0 = load doubleword.
REQ-008 req_addr  input  64  byte address.
REQ-009 req_wdata  input  64  store data.
REQ-010 rsp_valid  output  1  a response is presented.
REQ-011 rsp_ready  input  1  the requester accepts the response.
REQ-012 rsp_rdata  output  64  load data; 0 for stores and for errors.
REQ-013 rsp_error  output  1  the request was misaligned or out of range.
REQ-014 dbg_word0..dbg_word4  output  64 each  live contents of doublewords 0..4, for waveform inspection.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESPOND.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted on the edge where req_valid && req_ready.
REQ-017 On acceptance, the block SHALL capture write, addr and wdata.
  - LATENCY > 0: load the wait counter with LATENCY-1 and go to WAIT.
  - LATENCY = 0: commit immediately and go to RESPOND.
REQ-018 In WAIT, the counter SHALL decrement each cycle; on the edge where it is 0, the block SHALL commit and go to RESPOND.
REQ-019 Commit, reads: rsp_rdata <= mem[addr[63:3]].
REQ-020 Commit, writes: mem[addr[63:3]] <= wdata and rsp_rdata <= 0.
REQ-021 Error condition: error = (addr[2:0] != 0) || (addr[63:3] >= DEPTH).
  - On error: no array write, rsp_rdata = 0, rsp_error = 1.
REQ-022 rsp_valid SHALL be 1 exactly in RESPOND.
  - rsp_valid first rises LATENCY+1 cycles after the acceptance edge.
  - It stays high with rsp_rdata and rsp_error stable until the edge where rsp_ready = 1; the FSM then returns to IDLE.
REQ-023 There SHALL be no request overlap.
  - A new request is accepted no earlier than the cycle after the response handshake.
  - Minimum period: LATENCY+2 cycles when rsp_ready is held at 1.
REQ-024 A write followed by a read of the same address SHALL return the newly written data.
REQ-025 rsp_error and rsp_rdata SHALL be 0 whenever rsp_valid = 0.
REQ-026 req_valid while req_ready = 0 SHALL be ignored; the request is not queued.
REQ-027 dbg_word0..dbg_word4 SHALL reflect the array combinationally; for DEPTH < 5, the missing words read as 0.

Reset
REQ-028 When reset = 0 at a rising edge, the block SHALL set:
  - state IDLE, counter 0, req_ready = 1 in the following cycle;
  - rsp_valid = 0, rsp_rdata = 0, rsp_error = 0;
  - every array word to 0.
REQ-029 Reset in WAIT SHALL abort the request; an uncommitted write is discarded.
REQ-030 Reset in RESPOND SHALL drop the pending response without a handshake.
REQ-031 Reset SHALL take priority over acceptance, commit and handshake in the same cycle.

Structure
REQ-032 A shared package SHALL hold:
  - the state encoding (IDLE = 2'd0, WAIT = 2'd1, RESPOND = 2'd2);
  - the doubleword width constant 64;
  - the address offset width constant 3.
REQ-033 The array SHALL be a sub-module, dmr_array: one synchronous write port, one combinational read port, five debug taps, synchronous active-low clear.
  - The FSM, counter and error logic live in data_mem_responder.

Verification
REQ-034 Reset: hold reset = 0 for 2 cycles, then release -> req_ready = 1, rsp_valid = 0, dbg_word0..4 = 0.
REQ-035 Write then read, LATENCY = 2, rsp_ready = 1:
  - write addr 0x10, data 0xDEADBEEF_CAFEF00D -> rsp_valid on the 3rd cycle after acceptance, rsp_error = 0, dbg_word2 = 0xDEADBEEF_CAFEF00D;
  - then read 0x10 -> rsp_rdata = 0xDEADBEEF_CAFEF00D.
REQ-036 Errors:
  - write addr 0x0C -> rsp_error = 1, array unchanged;
  - read addr 0x200 with DEPTH = 64 -> rsp_error = 1, rsp_rdata = 0.
REQ-037 Backpressure: hold rsp_ready = 0 for 5 cycles during a read -> rsp_valid and rsp_rdata are stable throughout, req_ready = 0, and an extra req_valid pulse is ignored.
REQ-038 Abort: assert reset in WAIT during a write to addr 0x08, data 0x1234 -> dbg_word1 = 0 and no rsp_valid afterwards.
REQ-039 LATENCY = 0, back-to-back requests with rsp_ready = 1 -> one accepted request per 2 cycles, rsp_valid the cycle after acceptance.
